// File: rtl/video_timing_gen_if.sv
// Pixel-side bundle between the raster timing generator and its consumer.
// The consumer drives the clock enable; the generator drives coordinates and sync.
interface video_timing_gen_if #(
  parameter int COORD_W = 13
);
  logic               ce;
  logic [2:0]         o_hve;
  logic [COORD_W-1:0] o_x;
  logic [COORD_W-1:0] o_y;
  logic               o_lineStart;
  logic               o_frameStart;
  logic [COORD_W-1:0] o_ax;
  logic [COORD_W-1:0] o_ay;
  logic               o_ade;

  modport master (
    input  ce,
    output o_hve, o_x, o_y, o_lineStart, o_frameStart, o_ax, o_ay, o_ade
  );

  modport slave (
    output ce,
    input  o_hve, o_x, o_y, o_lineStart, o_frameStart, o_ax, o_ay, o_ade
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with a look-ahead coordinate pair that
// leads the displayed position so pipelined pixel sources can fetch early.
module video_timing_gen #(
  parameter int   H_RESOLUTION    = 640,
  parameter int   H_FRONT_PORCH   = 16,
  parameter int   H_SYNC          = 96,
  parameter int   H_BACK_PORCH    = 48,
  parameter int   V_RESOLUTION    = 480,
  parameter int   V_FRONT_PORCH   = 10,
  parameter int   V_SYNC          = 2,
  parameter int   V_BACK_PORCH    = 33,
  parameter logic H_SYNC_POLARITY = 1'b0,
  parameter logic V_SYNC_POLARITY = 1'b0,
  parameter int   LOOKAHEAD       = 2,
  parameter int   COORD_W         = 13
) (
  input  logic                clk,
  input  logic                resetN,
  video_timing_gen_if.master  vif
);
  localparam int H_TOTAL = H_RESOLUTION + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = V_RESOLUTION + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

  typedef logic [COORD_W-1:0] coord_t;
  // One extra bit so bounds equal to 2^COORD_W still compare correctly.
  typedef logic [COORD_W:0]   ext_t;

  localparam ext_t H_LAST   = ext_t'(H_TOTAL - 1);
  localparam ext_t V_LAST   = ext_t'(V_TOTAL - 1);
  localparam ext_t H_ACT    = ext_t'(H_RESOLUTION);
  localparam ext_t V_ACT    = ext_t'(V_RESOLUTION);
  localparam ext_t HS_START = ext_t'(H_RESOLUTION + H_FRONT_PORCH);
  localparam ext_t HS_END   = ext_t'(H_RESOLUTION + H_FRONT_PORCH + H_SYNC);
  localparam ext_t VS_START = ext_t'(V_RESOLUTION + V_FRONT_PORCH);
  localparam ext_t VS_END   = ext_t'(V_RESOLUTION + V_FRONT_PORCH + V_SYNC);

  function automatic logic [2*COORD_W-1:0] advance(input coord_t px, input coord_t py);
    coord_t nx;
    coord_t ny;
    nx = px + 1'b1;
    ny = py;
    if (ext_t'(px) == H_LAST) begin
      nx = '0;
      ny = (ext_t'(py) == V_LAST) ? '0 : py + 1'b1;
    end
    return {nx, ny};
  endfunction

  function automatic logic in_active(input coord_t px, input coord_t py);
    return (ext_t'(px) < H_ACT) && (ext_t'(py) < V_ACT);
  endfunction

  logic   started_reg;
  coord_t x_reg, y_reg, ax_reg, ay_reg;
  coord_t x_next, y_next, ax_next, ay_next;
  logic   hsync_reg, vsync_reg, de_reg, line_start_reg, frame_start_reg, ade_reg;
  logic   hsync_next, vsync_next;

  // The first enabled edge after reset only publishes the reset position.
  always_comb begin
    {x_next, y_next}   = {x_reg, y_reg};
    {ax_next, ay_next} = {ax_reg, ay_reg};
    if (started_reg) begin
      {x_next, y_next}   = advance(x_reg, y_reg);
      {ax_next, ay_next} = advance(ax_reg, ay_reg);
    end
    hsync_next = ((ext_t'(x_next) >= HS_START) && (ext_t'(x_next) < HS_END))
               ? H_SYNC_POLARITY : ~H_SYNC_POLARITY;
    vsync_next = ((ext_t'(y_next) >= VS_START) && (ext_t'(y_next) < VS_END))
               ? V_SYNC_POLARITY : ~V_SYNC_POLARITY;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      started_reg     <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      ax_reg          <= coord_t'(LOOKAHEAD);
      ay_reg          <= '0;
      hsync_reg       <= ~H_SYNC_POLARITY;
      vsync_reg       <= ~V_SYNC_POLARITY;
      de_reg          <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      ade_reg         <= 1'b0;
    end else if (vif.ce) begin
      started_reg     <= 1'b1;
      x_reg           <= x_next;
      y_reg           <= y_next;
      ax_reg          <= ax_next;
      ay_reg          <= ay_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      de_reg          <= in_active(x_next, y_next);
      line_start_reg  <= (x_next == '0);
      frame_start_reg <= (x_next == '0) && (y_next == '0);
      ade_reg         <= in_active(ax_next, ay_next);
    end
  end

  assign vif.o_hve        = {hsync_reg, vsync_reg, de_reg};
  assign vif.o_x          = x_reg;
  assign vif.o_y          = y_reg;
  assign vif.o_lineStart  = line_start_reg;
  assign vif.o_frameStart = frame_start_reg;
  assign vif.o_ax         = ax_reg;
  assign vif.o_ay         = ay_reg;
  assign vif.o_ade        = ade_reg;
endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised-ce bench for video_timing_gen: two instances (polarity/look-ahead
// variants) checked every cycle against a position-index model of the raster.
module tb_video_timing_gen;
  localparam int HR = 8, HFP = 2, HS = 3, HBP = 1;
  localparam int VR = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HR + HFP + HS + HBP;
  localparam int VT = VR + VFP + VS + VBP;
  localparam int FR = HT * VT;
  localparam int CW = 13;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic ce = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.COORD_W(CW)) vif0 ();
  video_timing_gen_if #(.COORD_W(CW)) vif1 ();
  assign vif0.ce = ce;
  assign vif1.ce = ce;

  video_timing_gen #(
    .H_RESOLUTION(HR), .H_FRONT_PORCH(HFP), .H_SYNC(HS), .H_BACK_PORCH(HBP),
    .V_RESOLUTION(VR), .V_FRONT_PORCH(VFP), .V_SYNC(VS), .V_BACK_PORCH(VBP),
    .H_SYNC_POLARITY(1'b0), .V_SYNC_POLARITY(1'b0), .LOOKAHEAD(3), .COORD_W(CW)
  ) dut0 (.clk(clk), .resetN(resetN), .vif(vif0.master));

  video_timing_gen #(
    .H_RESOLUTION(HR), .H_FRONT_PORCH(HFP), .H_SYNC(HS), .H_BACK_PORCH(HBP),
    .V_RESOLUTION(VR), .V_FRONT_PORCH(VFP), .V_SYNC(VS), .V_BACK_PORCH(VBP),
    .H_SYNC_POLARITY(1'b1), .V_SYNC_POLARITY(1'b1), .LOOKAHEAD(0), .COORD_W(CW)
  ) dut1 (.clk(clk), .resetN(resetN), .vif(vif1.master));

  typedef struct packed {
    logic [2:0]  hve;
    logic [12:0] x, y, ax, ay;
    logic        ls, fs, ade;
  } obs_t;

  obs_t obs0, obs1;
  assign obs0 = {vif0.o_hve, vif0.o_x, vif0.o_y, vif0.o_ax, vif0.o_ay,
                 vif0.o_lineStart, vif0.o_frameStart, vif0.o_ade};
  assign obs1 = {vif1.o_hve, vif1.o_x, vif1.o_y, vif1.o_ax, vif1.o_ay,
                 vif1.o_lineStart, vif1.o_frameStart, vif1.o_ade};

  // Model state: number of enabled edges since reset release.
  int   n;
  logic adv;
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      n   <= 0;
      adv <= 1'b0;
    end else begin
      if (ce) n <= n + 1;
      adv <= ce;
    end
  end

  // Edge count -> raster index (first enabled edge shows index 0).
  function automatic obs_t expect_at(input int cnt, input int la, input logic hp, input logic vp);
    obs_t e;
    int   k, ka, x, y, axi, ayi;
    bit   hs_on, vs_on;
    if (cnt == 0) begin
      e.hve = {~hp, ~vp, 1'b0};
      e.x = '0; e.y = '0; e.ax = 13'(la); e.ay = '0;
      e.ls = 1'b0; e.fs = 1'b0; e.ade = 1'b0;
      return e;
    end
    k   = (cnt - 1) % FR;
    x   = k % HT;
    y   = k / HT;
    ka  = (k + la) % FR;
    axi = ka % HT;
    ayi = ka / HT;
    hs_on = (x >= HR + HFP) && (x < HR + HFP + HS);
    vs_on = (y >= VR + VFP) && (y < VR + VFP + VS);
    e.hve = {hs_on ? hp : ~hp, vs_on ? vp : ~vp, (x < HR) && (y < VR)};
    e.x = 13'(x); e.y = 13'(y); e.ax = 13'(axi); e.ay = 13'(ayi);
    e.ls  = (x == 0);
    e.fs  = (x == 0) && (y == 0);
    e.ade = (axi < HR) && (ayi < VR);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t n=%0d)", name, act, exp, $time, n);
  endtask

  int   last_fs = -1;
  logic ade_hist [4];

  always @(negedge clk) begin
    check("dut0_cycle", 64'(obs0), 64'(expect_at(n, 3, 1'b0, 1'b0)));
    check("dut1_cycle", 64'(obs1), 64'(expect_at(n, 0, 1'b1, 1'b1)));
    if (n == 0) last_fs = -1;
    if (adv && n > 0) begin
      if (vif0.o_frameStart) begin
        if (last_fs >= 0) check("frame_period", 64'(n - last_fs), 64'(FR));
        last_fs = n;
      end
      if (n >= 4) check("ade_leads_de", 64'(ade_hist[(n - 3) % 4]), 64'(vif0.o_hve[0]));
      ade_hist[n % 4] = vif0.o_ade;
    end
  end

  task automatic step(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    resetN = 1'b0;
    ce     = 1'b0;
    step(3);
    check("rst_x",   64'(vif0.o_x), 64'd0);
    check("rst_hve", 64'(vif0.o_hve), 64'b110);
    check("rst_ax",  64'(vif0.o_ax), 64'd3);
    check("rst_fs",  64'(vif0.o_frameStart), 64'd0);
    resetN = 1'b1;
    ce     = 1'b1;
    step(1);
    $display("phase first_edge x=%0d y=%0d", vif0.o_x, vif0.o_y);
    check("first_xy", 64'({vif0.o_x, vif0.o_y}), 64'd0);
    check("first_de", 64'(vif0.o_hve[0]), 64'd1);
    check("first_fs", 64'(vif0.o_frameStart), 64'd1);
    check("first_ax", 64'(vif0.o_ax), 64'd3);
    step(13);
    check("line_end_x", 64'(vif0.o_x), 64'd13);
    check("line_end_y", 64'(vif0.o_y), 64'd0);
    step(1);
    check("line2_xy", 64'({vif0.o_x, vif0.o_y}), 64'({13'd0, 13'd1}));
    check("line2_ls", 64'(vif0.o_lineStart), 64'd1);
    // n is now 15; index 109 is (x=11, y=7)
    step(95);
    $display("phase wrap x=%0d y=%0d ax=%0d ay=%0d", vif0.o_x, vif0.o_y, vif0.o_ax, vif0.o_ay);
    check("wrap_xy",   64'({vif0.o_x, vif0.o_y}), 64'({13'd11, 13'd7}));
    check("wrap_axay", 64'({vif0.o_ax, vif0.o_ay}), 64'd0);
    step(13);
    check("hsync_pol0", 64'(vif0.o_hve[2]), 64'd0);
    check("hsync_pol1", 64'(vif1.o_hve[2]), 64'd1);
    check("hsync_x",    64'(vif0.o_x), 64'd10);
    step(3 * FR);
    $display("phase random_ce");
    for (int i = 0; i < 600; i++) begin
      ce = 1'($urandom % 2);
      step(1);
    end
    ce = 1'b1;
    for (int i = 0; i < 2 * FR && ((n - 1) % FR) != 34; i++) step(1);
    check("mid_xy", 64'({vif0.o_x, vif0.o_y}), 64'({13'd6, 13'd2}));
    ce = 1'b0;
    #1;
    resetN = 1'b0;
    #1;
    $display("phase async_reset x=%0d de=%0d", vif0.o_x, vif0.o_hve[0]);
    check("async_x",   64'(vif0.o_x), 64'd0);
    check("async_hve", 64'(vif0.o_hve), 64'b110);
    check("async_ax",  64'(vif0.o_ax), 64'd3);
    check("async_all", 64'(obs1), 64'(expect_at(0, 0, 1'b1, 1'b1)));
    step(2);
    resetN = 1'b1;
    ce     = 1'b1;
    step(1);
    check("rerun_xy", 64'({vif0.o_x, vif0.o_y}), 64'd0);
    check("rerun_fs", 64'(vif0.o_frameStart), 64'd1);
    $display("phase random_ce_reset");
    for (int i = 0; i < 700; i++) begin
      ce     = 1'($urandom % 2);
      resetN = ($urandom % 150) != 0;
      step(1);
    end
    resetN = 1'b1;
    step(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the HDMI/composite video path. It produces pixel coordinates, horizontal and vertical sync, data-enable, and line/frame strobes for any mode described by its parameters. It also produces a second coordinate set running a fixed number of pixel clocks ahead, so a pipelined pixel source (VideoRAM, character generator) can fetch early and land its data aligned with `de`. It sits between the pixel-clock domain's clock divider and the HDMI encoder, and succeeds the fixed-latency display signal generator.

## Interface

Parameters:
- `H_RESOLUTION`, 640: visible pixels per line.
- `H_FRONT_PORCH`, 16: pixel clocks from end of active video to hsync start.
- `H_SYNC`, 96: hsync width in pixel clocks.
- `H_BACK_PORCH`, 48: pixel clocks from hsync end to line end.
- `V_RESOLUTION`, 480: visible lines per frame.
- `V_FRONT_PORCH`, 10: lines before vsync.
- `V_SYNC`, 2: vsync width in lines.
- `V_BACK_PORCH`, 33: lines after vsync.
- `H_SYNC_POLARITY`, 0: hsync level when active (0 = active-low).
- `V_SYNC_POLARITY`, 0: vsync level when active.
- `LOOKAHEAD`, 2: pixel clocks by which `ax`/`ay` lead `x`/`y`. Legal range 0..H_TOTAL-1.
- `COORD_W`, 13: width of all coordinate outputs.
- Derived: H_TOTAL = sum of the four H terms; V_TOTAL = sum of the four V terms.

Ports:
- `clk`, in, 1: pixel clock. One clock; all logic on the rising edge.
- `resetN`, in, 1: asynchronous, active-low reset.
- `ce`, in, 1: clock enable. When low, all state and outputs hold.
- `o_hve`, out, 3: [2] hsync, [1] vsync, [0] de. All three match `o_x`/`o_y` of the same cycle.
- `o_x`, out, COORD_W: current horizontal position, 0..H_TOTAL-1.
- `o_y`, out, COORD_W: current line, 0..V_TOTAL-1.
- `o_lineStart`, out, 1: high while `o_x`==0.
- `o_frameStart`, out, 1: high while `o_x`==0 and `o_y`==0.
- `o_ax`, out, COORD_W: look-ahead horizontal position.
- `o_ay`, out, COORD_W: look-ahead line.
- `o_ade`, out, 1: data-enable for the look-ahead position.

## Operation

- Raster order within a line: active 0..H_RESOLUTION-1, then front porch, then sync, then back porch. Vertical order is the same.
- The main counter pair (x, y) and the look-ahead counter pair (ax, ay) are independent registers. Both advance by one position on every rising edge with `ce`=1.
- Advance rule:
  - x increments; at x==H_TOTAL-1 it wraps to 0 and y increments.
  - At x==H_TOTAL-1 and y==V_TOTAL-1, both wrap to 0.
  - ax/ay follow the identical rule.
- Outputs are registered and decoded from the *next* position, so every output is valid in the same cycle as its coordinate (no decode lag).
- de = (x < H_RESOLUTION) && (y < V_RESOLUTION).
- hsync active while H_RESOLUTION+H_FRONT_PORCH ≤ x < H_RESOLUTION+H_FRONT_PORCH+H_SYNC. Otherwise it sits at the inactive level (~H_SYNC_POLARITY).
- vsync active for entire lines with V_RESOLUTION+V_FRONT_PORCH ≤ y < V_RESOLUTION+V_FRONT_PORCH+V_SYNC. vsync edges coincide with x==0.
- ade uses the de formula applied to ax/ay.
- Invariant: (ax, ay) always equals (x, y) advanced LOOKAHEAD positions, wrapping across line and frame. With LOOKAHEAD=0 the two sets are identical.
- Width rule: counters are COORD_W bits. H_TOTAL and V_TOTAL must be ≤ 2^COORD_W. Comparisons are unsigned.

## Timing

- Reset (resetN low, asynchronous):
  - x=0, y=0; de=0; hsync and vsync inactive.
  - lineStart=0, frameStart=0.
  - ax=LOOKAHEAD, ay=0, ade=0.
- First `ce` edge after reset release:
  - Outputs show position (0,0) with de=1 (V_RESOLUTION and H_RESOLUTION are nonzero), lineStart=1, frameStart=1.
  - ax=LOOKAHEAD, ay=0, ade as decoded.
  - x and ax do not advance on this edge.
  - From the next `ce` edge on, both sets advance one position per edge.
- `ce` low: every output holds its value, including strobes; strobes are level, not pulse-stretched.
- Reset asserted mid-frame forces all outputs to their reset values immediately, with no wait for `clk`. The counters restart from the first-edge behaviour above.
- Frame period is H_TOTAL×V_TOTAL enabled cycles. Successive frameStart assertions are exactly that far apart.

## Test plan

Sim configuration unless stated otherwise: H=8/2/3/1 (H_TOTAL=14), V=4/1/2/1 (V_TOTAL=8), LOOKAHEAD=3.

- Reset release, `ce`=1 → first edge gives x=0, y=0, de=1, frameStart=1, ax=3. After 13 more edges, x=13, y=0. The next edge gives x=0, y=1, lineStart=1.
- One full line → de=1 for x 0..7; hsync active for x 10..12 at the level set by H_SYNC_POLARITY; run once with polarity 0 and once with polarity 1.
- Full frame → vsync active on lines 5..6 and toggles only at x==0. frameStart recurs every 112 enabled cycles. ade is never 1 while ay ≥ 4.
- Look-ahead wrap → when x=11, y=7, expect ax=0, ay=0. For every cycle of 3 frames, ade equals the de seen 3 cycles later. Repeat with LOOKAHEAD=0 and check ax==x and ay==y throughout.
- `ce` toggled with a random 50% pattern → sequence of positions identical to the `ce`=1 run once stalled cycles are removed; outputs constant during stalls.
- resetN pulsed low asynchronously mid-line (x=6, y=2) → outputs reach reset values without a clock edge. Re-release repeats the first-edge behaviour. Default 640×480 parameters give H_TOTAL=800, V_TOTAL=525, 420000 cycles per frame.
